// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU pipeline stages: datapath widths, the
// memory-stage state encoding and the default data-bus timeout.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN         = 32;  // datapath / address width
    localparam int REG_W        = 5;   // register-file index width
    localparam int DMEM_TIMEOUT = 15;  // default max cycles of dmem_req without ack

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage : cpu_pkg

// File: rtl/mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. Loads a new write-back record every cycle unless
// bubble_i is set, in which case it inserts a bubble: the write enable and
// the fault flag are cleared, and rd/data keep their previous values.
//
// Ports:
//   clk      in   clock, rising edge
//   clr      in   asynchronous active-high clear
//   bubble_i in   insert a bubble instead of loading the record
//   we_i     in   write enable for rd
//   rd_i     in   destination register
//   data_i   in   write-back data
//   fault_i  in   instruction faulted
//   we_o     out  registered write enable
//   rd_o     out  registered destination register
//   data_o   out  registered write-back data
//   fault_o  out  registered fault flag
// ---------------------------------------------------------------------------
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             bubble_i,
    input  logic             we_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [XLEN-1:0]  data_i,
    input  logic             fault_i,
    output logic             we_o,
    output logic [REG_W-1:0] rd_o,
    output logic [XLEN-1:0]  data_o,
    output logic             fault_o
);

    logic             we_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  data_q;
    logic             fault_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else if (bubble_i) begin
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            we_q    <= we_i;
            rd_q    <= rd_i;
            data_q  <= data_i;
            fault_q <= fault_i;
        end
    end

    assign we_o    = we_q;
    assign rd_o    = rd_q;
    assign data_o  = data_q;
    assign fault_o = fault_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access pipeline stage. Takes the EX/MEM outputs, performs word
// loads/stores over a req/ack data-memory bus, stalls upstream while an
// access is outstanding, aborts an access that waits too long for ack, and
// registers the write-back result into the MEM/WB register.
//
// Parameters:
//   TIMEOUT  max cycles dmem_req may stay high without ack (0 = never abort)
//   TO_W     timeout counter width, 2**TO_W > TIMEOUT
//
// Ports:
//   clk, clr                  clock / asynchronous active-high reset
//   ALU_WB, mem_write,
//   write_enable, bubble      EX/MEM control
//   ALU, write_data, rd       EX/MEM data (ALU is also the memory address)
//   stall_out                 hold EX/MEM and earlier stages (combinational)
//   dmem_req/we/addr/wdata    registered data-memory bus request
//   dmem_rdata, dmem_ack      data-memory bus response
//   wb_write_enable, wb_rd,
//   wb_data, wb_fault         MEM/WB register outputs
// ---------------------------------------------------------------------------
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT,
    parameter int TO_W    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ALU_WB,
    input  logic             mem_write,
    input  logic             write_enable,
    input  logic             bubble,
    input  logic [XLEN-1:0]  ALU,
    input  logic [XLEN-1:0]  write_data,
    input  logic [REG_W-1:0] rd,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ack,
    output logic             wb_write_enable,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_fault
);

    mem_state_e      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            dwe_q, dwe_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    // MEM/WB register inputs
    logic             wb_bubble;
    logic             wb_we_n;
    logic [REG_W-1:0] wb_rd_n;
    logic [XLEN-1:0]  wb_data_n;
    logic             wb_fault_n;

    // Instruction classification; a bubble slot is always a no-op.
    logic is_load, is_store, mem_op, misaligned, timeout_hit;

    assign is_load    = ~bubble & write_enable & ~ALU_WB & ~mem_write;
    assign is_store   = ~bubble & mem_write;
    assign mem_op     = is_load | is_store;
    assign misaligned = mem_op & (ALU[1:0] != 2'b00);

    // The counter holds the number of completed BUSY cycles, so hitting
    // TIMEOUT-1 in the current cycle means dmem_req has been high TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            dwe_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            dwe_q   <= dwe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        dwe_d      = dwe_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stall_out  = 1'b0;
        wb_bubble  = 1'b1;
        wb_we_n    = 1'b0;
        wb_rd_n    = rd;
        wb_data_n  = ALU;
        wb_fault_n = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    // Fault straight into MEM/WB; the bus is never touched.
                    wb_bubble  = 1'b0;
                    wb_data_n  = '0;
                    wb_fault_n = 1'b1;
                end else if (mem_op) begin
                    stall_out = 1'b1;
                    req_d     = 1'b1;
                    dwe_d     = is_store;
                    addr_d    = ALU;
                    wdata_d   = write_data;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end else begin
                    wb_bubble = 1'b0;
                    wb_we_n   = write_enable & ~bubble;
                end
            end

            ST_BUSY: begin
                // Ack takes priority over a timeout in the same cycle.
                stall_out = ~dmem_ack & ~timeout_hit;
                if (dmem_ack) begin
                    req_d     = 1'b0;
                    state_d   = ST_IDLE;
                    wb_bubble = 1'b0;
                    wb_we_n   = is_load;
                    wb_data_n = is_load ? dmem_rdata : ALU;
                end else if (timeout_hit) begin
                    req_d      = 1'b0;
                    state_d    = ST_IDLE;
                    wb_bubble  = 1'b0;
                    wb_data_n  = '0;
                    wb_fault_n = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign dmem_req   = req_q;
    assign dmem_we    = dwe_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    mem_wb_reg u_mem_wb (
        .clk      (clk),
        .clr      (clr),
        .bubble_i (wb_bubble),
        .we_i     (wb_we_n),
        .rd_i     (wb_rd_n),
        .data_i   (wb_data_n),
        .fault_i  (wb_fault_n),
        .we_o     (wb_write_enable),
        .rd_o     (wb_rd),
        .data_o   (wb_data),
        .fault_o  (wb_fault)
    );

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage (TIMEOUT = 4). Inputs change
// 1 time unit after a rising edge; outputs are compared 1 unit later
// (combinational stall) or 1 unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        clr;
    logic        ALU_WB, mem_write, write_enable, bubble;
    logic [31:0] ALU, write_data;
    logic [4:0]  rd;
    logic        stall_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_write_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_stage #(.TIMEOUT(4), .TO_W(4)) dut (
        .clk             (clk),
        .clr             (clr),
        .ALU_WB          (ALU_WB),
        .mem_write       (mem_write),
        .write_enable    (write_enable),
        .bubble          (bubble),
        .ALU             (ALU),
        .write_data      (write_data),
        .rd              (rd),
        .stall_out       (stall_out),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .wb_write_enable (wb_write_enable),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .wb_fault        (wb_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic set_op(input logic alu_wb_v, input logic mw_v, input logic we_v,
                          input logic bub_v, input logic [31:0] alu_v,
                          input logic [31:0] wd_v, input logic [4:0] rd_v);
        ALU_WB       = alu_wb_v;
        mem_write    = mw_v;
        write_enable = we_v;
        bubble       = bub_v;
        ALU          = alu_v;
        write_data   = wd_v;
        rd           = rd_v;
    endtask

    task automatic set_nop();
        set_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_write_enable, wb_rd, wb_data, wb_fault} !== '0) begin
            err_cnt++;
            $display("FAIL reset_async: req=%b we=%b addr=%h wdata=%h wb_we=%b wb_rd=%0d wb_data=%h wb_fault=%b, required all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_write_enable, wb_rd, wb_data, wb_fault);
        end
        edge_wait();
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_fault, wb_data} !== '0) begin
            err_cnt++;
            $display("FAIL reset_held: req=%b wb_we=%b wb_fault=%b wb_data=%h, required all 0",
                     dmem_req, wb_write_enable, wb_fault, wb_data);
        end
        #2 clr = 1'b0;
        edge_wait();
    endtask

    task automatic test_alu_op();
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        #1;
        vec_cnt++;
        if (stall_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_stall: got %b required 0", stall_out);
        end
        edge_wait();
        vec_cnt++;
        if ({wb_write_enable, wb_rd, wb_data, wb_fault, dmem_req} !== {1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL alu_wb: wb_we=%b wb_rd=%0d wb_data=%h wb_fault=%b req=%b, required 1 5 00001234 0 0",
                     wb_write_enable, wb_rd, wb_data, wb_fault, dmem_req);
        end
        set_nop();
    endtask

    task automatic test_load();
        int stall_cycles;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7);
        #1;
        stall_cycles = (stall_out === 1'b1) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            edge_wait();
            if (stall_out === 1'b1) stall_cycles++;
            vec_cnt++;
            if ({dmem_req, dmem_we, dmem_addr, wb_write_enable, wb_fault} !== {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("FAIL load_busy[%0d]: req=%b we=%b addr=%h wb_we=%b wb_fault=%b, required 1 0 00000100 0 0",
                         i, dmem_req, dmem_we, dmem_addr, wb_write_enable, wb_fault);
            end
        end
        vec_cnt++;
        if (stall_cycles != 3) begin
            err_cnt++;
            $display("FAIL load_stall_cycles: got %0d required 3", stall_cycles);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        vec_cnt++;
        if (stall_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_ack_stall: got %b required 0", stall_out);
        end
        edge_wait();
        dmem_ack = 1'b0;
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_rd, wb_data, wb_fault} !== {1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0}) begin
            err_cnt++;
            $display("FAIL load_wb: req=%b wb_we=%b wb_rd=%0d wb_data=%h wb_fault=%b, required 0 1 7 deadbeef 0",
                     dmem_req, wb_write_enable, wb_rd, wb_data, wb_fault);
        end
        set_nop();
        edge_wait();
    endtask

    task automatic test_store();
        set_op(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd3);
        #1;
        vec_cnt++;
        if (stall_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL store_issue_stall: got %b required 1", stall_out);
        end
        edge_wait();
        vec_cnt++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D}) begin
            err_cnt++;
            $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h, required 1 1 00000200 cafef00d",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        dmem_ack = 1'b1;
        #1;
        vec_cnt++;
        if (stall_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL store_ack_stall: got %b required 0", stall_out);
        end
        edge_wait();
        dmem_ack = 1'b0;
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_fault} !== 3'b000) begin
            err_cnt++;
            $display("FAIL store_wb: req=%b wb_we=%b wb_fault=%b, required 0 0 0",
                     dmem_req, wb_write_enable, wb_fault);
        end
        set_nop();
        edge_wait();
    endtask

    task automatic test_misaligned();
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd9);
        #1;
        vec_cnt++;
        if (stall_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL misalign_stall: got %b required 0", stall_out);
        end
        edge_wait();
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_fault, wb_rd, wb_data} !== {1'b0, 1'b0, 1'b1, 5'd9, 32'h0}) begin
            err_cnt++;
            $display("FAIL misalign_wb: req=%b wb_we=%b wb_fault=%b wb_rd=%0d wb_data=%h, required 0 0 1 9 00000000",
                     dmem_req, wb_write_enable, wb_fault, wb_rd, wb_data);
        end
        set_nop();
        edge_wait();
        vec_cnt++;
        if (wb_fault !== 1'b0) begin
            err_cnt++;
            $display("FAIL misalign_fault_pulse: got %b required 0", wb_fault);
        end
    endtask

    task automatic test_timeout();
        int req_cycles;
        logic [3:0] stall_seen;
        req_cycles = 0;
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            edge_wait();
            if (dmem_req === 1'b1) req_cycles++;
            stall_seen[i] = stall_out;
        end
        vec_cnt++;
        if (stall_seen !== 4'b0111) begin
            err_cnt++;
            $display("FAIL timeout_stall: got %b required 0111 (bit i = busy cycle i)", stall_seen);
        end
        edge_wait();
        if (dmem_req === 1'b1) req_cycles++;
        vec_cnt++;
        if (req_cycles != 4) begin
            err_cnt++;
            $display("FAIL timeout_req_cycles: got %0d required 4", req_cycles);
        end
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_fault} !== 3'b001) begin
            err_cnt++;
            $display("FAIL timeout_wb: req=%b wb_we=%b wb_fault=%b, required 0 0 1",
                     dmem_req, wb_write_enable, wb_fault);
        end
        // Late ack after the abort must have no effect.
        set_nop();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        edge_wait();
        dmem_ack = 1'b0;
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_fault, stall_out} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL timeout_late_ack: req=%b wb_we=%b wb_fault=%b stall=%b, required 0 0 0 0",
                     dmem_req, wb_write_enable, wb_fault, stall_out);
        end
    endtask

    task automatic test_async_clear();
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0, 5'd6);
        edge_wait();
        set_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd2);
        edge_wait();
        vec_cnt++;
        if ({dmem_req, wb_write_enable, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd6, 32'h0000_ABCD}) begin
            err_cnt++;
            $display("FAIL clr_pre_busy: req=%b wb_we=%b wb_rd=%0d wb_data=%h, required 1 0 6 0000abcd",
                     dmem_req, wb_write_enable, wb_rd, wb_data);
        end
        #3 clr = 1'b1;
        #1;
        vec_cnt++;
        if ({dmem_req, dmem_addr, wb_write_enable, wb_rd, wb_data, wb_fault} !== '0) begin
            err_cnt++;
            $display("FAIL clr_async: req=%b addr=%h wb_we=%b wb_rd=%0d wb_data=%h wb_fault=%b, required all 0",
                     dmem_req, dmem_addr, wb_write_enable, wb_rd, wb_data, wb_fault);
        end
        set_nop();
        #2 clr = 1'b0;
        set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd1);
        #1;
        vec_cnt++;
        if ({stall_out, dmem_req} !== 2'b00) begin
            err_cnt++;
            $display("FAIL clr_release_idle: stall=%b req=%b, required 0 0", stall_out, dmem_req);
        end
        edge_wait();
        vec_cnt++;
        if ({wb_write_enable, wb_rd, wb_data, wb_fault, dmem_req} !== {1'b1, 5'd1, 32'h0000_0055, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("FAIL clr_after_alu: wb_we=%b wb_rd=%0d wb_data=%h wb_fault=%b req=%b, required 1 1 00000055 0 0",
                     wb_write_enable, wb_rd, wb_data, wb_fault, dmem_req);
        end
        set_nop();
    endtask

    initial begin
        clr        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_nop();
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_async_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_mem_stage

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM control/data outputs and performs word loads/stores on the data-memory bus using a req/ack handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the write-back result into an internal MEM/WB register that feeds the register file and the forwarding path.

Parameters:
- TIMEOUT, 15, max cycles dmem_req may stay high without dmem_ack before the access aborts; 0 disables the timeout.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- ALU_WB  in  1  1 = write back ALU result; 0 = write back load data.
- mem_write  in  1  store request.
- write_enable  in  1  instruction writes rd.
- bubble  in  1  slot is a bubble; treat as no-op.
- ALU  in  32  ALU result, which is also the memory address.
- write_data  in  32  store data.
- rd  in  5  destination register.
- stall_out  out  1  hold EX/MEM and earlier stages (combinational).
- dmem_req  out  1  bus request (registered).
- dmem_we  out  1  1 = store (registered).
- dmem_addr  out  32  word-aligned address (registered).
- dmem_wdata  out  32  store data (registered).
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  access complete; only meaningful while dmem_req = 1.
- wb_write_enable  out  1  MEM/WB: write rd.
- wb_rd  out  5  MEM/WB destination register.
- wb_data  out  32  MEM/WB write-back data.
- wb_fault  out  1  MEM/WB: misaligned access or bus timeout (one-cycle, per instruction).

Behaviour:
- Reset (clr = 1, asynchronous): state IDLE, timeout counter 0, and every registered output 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_write_enable, wb_rd, wb_data, wb_fault).
- Classification, when bubble = 0:
  - load = write_enable & ~ALU_WB & ~mem_write.
  - store = mem_write. A store never writes rd, even if write_enable = 1.
  - mem_op = load | store.
  - bubble = 1 forces a no-op.
- Misaligned: mem_op with ALU[1:0] != 0.
  - No bus access, no stall.
  - Next edge: wb_write_enable = 0, wb_fault = 1, wb_rd = rd, wb_data = 0.
- State machine: IDLE, BUSY.
- IDLE:
  - Non-memory op or bubble: next edge loads MEM/WB with write_enable & ~bubble, rd, ALU; wb_fault = 0. Latency 1, stall_out = 0.
  - Aligned mem_op:
    - stall_out = 1.
    - Next edge: dmem_req = 1, dmem_we = store, dmem_addr = ALU, dmem_wdata = write_data; counter cleared; go to BUSY.
    - MEM/WB loads a bubble (wb_write_enable = 0, wb_fault = 0).
- BUSY:
  - dmem_req, dmem_addr, dmem_wdata and dmem_we are held stable until the access completes.
  - stall_out = ~dmem_ack & ~timeout_hit, where timeout_hit = (TIMEOUT != 0) & (counter == TIMEOUT - 1).
  - No ack and no timeout: counter increments; MEM/WB loads a bubble.
  - dmem_ack = 1:
    - Next edge: dmem_req = 0, go to IDLE.
    - MEM/WB: wb_write_enable = load, wb_rd = rd, wb_data = dmem_rdata for a load else ALU, wb_fault = 0.
    - stall_out is low this cycle, so EX/MEM advances on the same edge; the access is never reissued.
  - timeout_hit with no ack:
    - Next edge: dmem_req = 0, go to IDLE.
    - MEM/WB: wb_write_enable = 0, wb_fault = 1.
  - Ack and timeout in the same cycle: ack wins.
- Timing: TIMEOUT = N allows at most N cycles of dmem_req high; acks after the abort are ignored.
- Inputs are held stable by the stall while in BUSY; the block does not re-sample them mid-access.
- wb_fault is high for exactly one cycle per faulting instruction.
- Minimum load/store latency is 2 cycles (IDLE to BUSY with same-cycle ack).

Decomposition:
- Shared package cpu_pkg: XLEN = 32, REG_W = 5, state encoding (ST_IDLE, ST_BUSY), the default bus-timeout constant.
- Sub-module mem_wb_reg: the MEM/WB output register with asynchronous clear and a bubble-insert input. It is reusable by later stages.
- The handshake/FSM stays in mem_stage.

Test Plan:
1. ALU op: ALU = 0x00001234, rd = 5, ALU_WB = 1, write_enable = 1 -> next edge wb_write_enable = 1, wb_rd = 5, wb_data = 0x00001234; stall_out never high; dmem_req stays 0.
2. Load at 0x00000100, rd = 7, ack 2 cycles after req rises with rdata = 0xDEADBEEF -> stall_out high for 3 cycles then low in the ack cycle; dmem_addr = 0x100, dmem_we = 0; wb_data = 0xDEADBEEF, wb_rd = 7, wb_write_enable = 1 one edge after ack; MEM/WB holds a bubble during the stall.
3. Store 0xCAFEF00D to 0x00000200 with ack in the first BUSY cycle -> dmem_we = 1, dmem_wdata = 0xCAFEF00D for 1 cycle; wb_write_enable = 0; stall high 1 cycle only.
4. Misaligned load at 0x00000102 -> dmem_req stays 0, no stall, next edge wb_fault = 1, wb_write_enable = 0.
5. TIMEOUT = 4, load with no ack -> dmem_req high exactly 4 cycles, then wb_fault = 1, wb_write_enable = 0, stall released; a late ack is ignored.
6. clr asserted mid-BUSY, not aligned to clk -> dmem_req and all wb_* drop to 0 immediately; after release, an ALU op completes normally in 1 cycle.
